serial_full_adder: RTL and testbench

// - Bit-serial WIDTH-bit full adder: the add-side counterpart of the full subtractor; computes A + B + CarryIn.
// - Processes one bit per clock, LSB first, through a single full-adder cell plus a carry flop.
// - Sits beside the subtractor blocks as the area-cheap multi-cycle arithmetic unit.
// - Start/Busy/Done handshake; the result is held stable until the next accepted operation.
//

---
 rtl/serial_full_adder.sv | 165 ++++++++++++++++
 tb/tb_serial_full_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_full_adder.sv
// ---------------------------------------------------------------------------
// serial_full_adder
//
// Bit-serial WIDTH-bit adder: computes A + B + CarryIn one bit per clock,
// LSB first, through a single full-adder cell and a carry flop. It is the
// small multi-cycle arithmetic unit that sits beside the subtractor blocks.
//
// Operands are latched when Start is accepted, so A, B and CarryIn may change
// afterwards. Sum and CarryOut are updated only when an operation completes
// and are held until the next completion.
//
// Optional feature: define SERIAL_ADD_OVERFLOW_EN to add the Overflow output,
// which reports two's-complement signed overflow of the completed operation.
//
// Ports
//   clk       in   1      clock, rising edge
//   rst       in   1      synchronous active-high reset
//   Start     in   1      request, sampled only while Busy=0
//   A, B      in   WIDTH  operands, latched on acceptance
//   CarryIn   in   1      carry into bit 0, latched on acceptance
//   Busy      out  1      addition in progress
//   Done      out  1      one-cycle pulse, Sum/CarryOut updated this cycle
//   Sum       out  WIDTH  registered result
//   CarryOut  out  1      registered carry out of bit WIDTH-1
//   Overflow  out  1      (SERIAL_ADD_OVERFLOW_EN only) signed overflow
//
// State table
//   IDLE | waiting for Start; last result held on Sum/CarryOut
//   RUN  | one operand bit pair summed per clock, LSB first
// ---------------------------------------------------------------------------
module serial_full_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CarryIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut
`ifdef SERIAL_ADD_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    logic bit_s;
    logic bit_c;

    // The single full-adder cell.
    assign bit_s = a_q[0] ^ b_q[0] ^ c_q;
    assign bit_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            psum_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            psum_q  <= psum_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        psum_d  = psum_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = CarryIn;
                    psum_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                c_d    = bit_c;
                // Sum bits enter at the MSB so bit 0 ends at position 0.
                psum_d = {bit_s, psum_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = {bit_s, psum_q[WIDTH-1:1]};
                    cout_d  = bit_c;
`ifdef SERIAL_ADD_OVERFLOW_EN
                    // c_q here is the carry into the MSB.
                    ovf_d   = c_q ^ bit_c;
`endif
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign Busy     = (state_q == RUN);
    assign Done     = done_q;
    assign Sum      = sum_q;
    assign CarryOut = cout_q;
`ifdef SERIAL_ADD_OVERFLOW_EN
    assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_full_adder.sv
module tb_serial_full_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         Start;
    logic [W-1:0] A, B;
    logic         CarryIn;
    logic         Busy, Done;
    logic [W-1:0] Sum;
    logic         CarryOut;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic         Overflow;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_full_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .A        (A),
        .B        (B),
        .CarryIn  (CarryIn),
        .Busy     (Busy),
        .Done     (Done),
        .Sum      (Sum),
        .CarryOut (CarryOut)
`ifdef SERIAL_ADD_OVERFLOW_EN
        ,
        .Overflow (Overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation starting at a falling edge; returns at the falling
    // edge of the Done cycle (or after a bounded wait).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output int busy_n, output int got_done);
        busy_n   = 0;
        got_done = 0;
        @(negedge clk);
        A = a; B = b; CarryIn = cin; Start = 1'b1;
        for (int i = 0; i < 20 && got_done == 0; i++) begin
            @(negedge clk);
            Start = 1'b0;
            if (Busy) busy_n++;
            if (Done) got_done = 1;
        end
    endtask

    vec_t vecs[7];

    initial begin
        int busy_n, got_done, dones, cyc;
        logic [W:0] ref_v;

        vecs[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[1] = '{4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0};
        vecs[2] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        vecs[3] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[4] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[5] = '{4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b1};
        vecs[6] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};

        rst = 1'b1; Start = 1'b0; A = '0; B = '0; CarryIn = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_sum", Sum, 0);
        check("reset_cout", CarryOut, 0);
`ifdef SERIAL_ADD_OVERFLOW_EN
        check("reset_ovf", Overflow, 0);
`endif
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, busy_n, got_done);
            check($sformatf("tbl%0d_done", i), got_done, 1);
            check($sformatf("tbl%0d_busy_cycles", i), busy_n, W);
            check($sformatf("tbl%0d_sum", i), Sum, vecs[i].sum);
            check($sformatf("tbl%0d_cout", i), CarryOut, vecs[i].cout);
`ifdef SERIAL_ADD_OVERFLOW_EN
            check($sformatf("tbl%0d_ovf", i), Overflow, vecs[i].ovf);
`endif
            @(negedge clk);
            check($sformatf("tbl%0d_done_pulse_len", i), Done, 0);
        end
        // Sum now holds 0000 / CarryOut=1 from the last vector.

        // Start while busy is ignored
        @(negedge clk);
        A = 4'b0011; B = 4'b0001; CarryIn = 1'b0; Start = 1'b1;
        @(negedge clk); Start = 1'b0;
        check("ign_sum_held", Sum, 0);
        @(negedge clk);
        A = 4'b1111; Start = 1'b1;
        @(negedge clk); Start = 1'b0;
        check("ign_cout_held", CarryOut, 1);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (Done) begin
                dones++;
                check("ign_sum", Sum, 4'b0100);
                check("ign_cout", CarryOut, 0);
            end
        end
        check("ign_done_count", dones, 1);

        // Start held across Done -> back-to-back
        @(negedge clk);
        A = 4'b0001; B = 4'b0001; CarryIn = 1'b0; Start = 1'b1;
        got_done = 0;
        for (int i = 0; i < 20 && got_done == 0; i++) begin
            @(negedge clk);
            if (Done) got_done = 1;
        end
        check("b2b_first_done", got_done, 1);
        check("b2b_first_sum", Sum, 4'b0010);
        A = 4'b0010; B = 4'b0011;
        @(negedge clk);
        Start = 1'b0;
        check("b2b_restart_busy", Busy, 1);
        got_done = 0;
        cyc = 1;
        for (int i = 0; i < 20 && got_done == 0; i++) begin
            @(negedge clk);
            cyc++;
            if (Done) got_done = 1;
            else if (Sum !== 4'b0010) check("b2b_sum_stable", Sum, 4'b0010);
        end
        check("b2b_second_done", got_done, 1);
        check("b2b_spacing", cyc, W + 1);
        check("b2b_second_sum", Sum, 4'b0101);

        // Reset in cycle 2 of an operation
        @(negedge clk);
        A = 4'b1111; B = 4'b1111; CarryIn = 1'b1; Start = 1'b1;
        @(negedge clk); Start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("rstmid_busy", Busy, 0);
        check("rstmid_sum", Sum, 0);
        check("rstmid_cout", CarryOut, 0);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (Done) dones++;
        end
        check("rstmid_no_done", dones, 0);
        do_op(4'b0010, 4'b0011, 1'b1, busy_n, got_done);
        check("rstmid_next_done", got_done, 1);
        check("rstmid_next_sum", Sum, 4'b0110);

        // Exhaustive
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    ref_v = 5'(a) + 5'(b) + 5'(c);
                    do_op(4'(a), 4'(b), 1'(c), busy_n, got_done);
                    if (got_done == 0)
                        check($sformatf("exh_done_%0d_%0d_%0d", a, b, c), got_done, 1);
                    else
                        check($sformatf("exh_%0d_%0d_%0d", a, b, c), {CarryOut, Sum}, ref_v);
                end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
